// File: rtl/spi_fifo_param_if.sv
// Handshake and status bundle for spi_fifo_param.
// master = producer/consumer side, slave = FIFO side.
interface spi_fifo_param_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 9
);
   logic              wr_en;
   logic [DATA_W-1:0] data_in;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic [CNT_W-1:0]  ae_level;
   logic [CNT_W-1:0]  af_level;
   logic              empty;
   logic              almost_empty;
   logic              full;
   logic              almost_full;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, data_in, rd_en, ae_level, af_level,
      input  data_out, data_valid, empty, almost_empty,
      input  full, almost_full, count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en, ae_level, af_level,
      output data_out, data_valid, empty, almost_empty,
      output full, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/spi_fifo_param.sv
// Parametrised synchronous FIFO for the Quad-SPI send/receive paths.
// Any depth 2..511, sticky error flags, show-ahead or registered read.
module spi_fifo_param #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 261,
   parameter int CNT_W      = 9,
   parameter bit SHOW_AHEAD = 1'b1
) (
   input logic              clk,
   input logic              reset,
   input logic              flush,
   spi_fifo_param_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_empty;
   logic              r_full;
   logic              r_ae;
   logic              r_af;
   logic              r_ovf;
   logic              r_unf;

   logic              w_clr;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [AW-1:0]     w_rd_ptr_nxt;
   logic [AW-1:0]     w_wr_ptr_nxt;

   assign w_clr    = reset || flush;
   assign w_rd_acc = bus.rd_en && !r_empty;
   // A full FIFO still takes a write when a read frees a slot the same cycle
   assign w_wr_acc = bus.wr_en && (!r_full || w_rd_acc);

   assign w_rd_ptr_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
   assign w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_wr_acc && !w_rd_acc)
         w_cnt_nxt = r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc)
         w_cnt_nxt = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_ae     <= 1'b1;
         r_af     <= (bus.af_level == '0);
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_rd_acc)
            r_rd_ptr <= w_rd_ptr_nxt;
         if (w_wr_acc)
            r_wr_ptr <= w_wr_ptr_nxt;
         r_count <= w_cnt_nxt;
         // Flags follow next-count so they never lag the count output
         r_empty <= (w_cnt_nxt == '0);
         r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
         r_ae    <= (w_cnt_nxt <= bus.ae_level);
         r_af    <= (w_cnt_nxt >= bus.af_level);
         r_ovf   <= r_ovf || (bus.wr_en && !w_wr_acc);
         r_unf   <= r_unf || (bus.rd_en && !w_rd_acc);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc && !w_clr)
         r_mem[r_wr_ptr] <= bus.data_in;
   end

   generate
      if (SHOW_AHEAD) begin : g_show_ahead
         assign bus.data_out   = r_mem[r_rd_ptr];
         assign bus.data_valid = !r_empty;
      end else begin : g_registered
         logic [DATA_W-1:0] r_dout;
         logic              r_dv;

         always_ff @(posedge clk) begin
            if (w_clr) begin
               r_dout <= '0;
               r_dv   <= 1'b0;
            end else begin
               r_dv <= w_rd_acc;
               if (w_rd_acc)
                  r_dout <= r_mem[r_rd_ptr];
            end
         end

         assign bus.data_out   = r_dout;
         assign bus.data_valid = r_dv;
      end
   endgenerate

   assign bus.count        = r_count;
   assign bus.empty        = r_empty;
   assign bus.full         = r_full;
   assign bus.almost_empty = r_ae;
   assign bus.almost_full  = r_af;
   assign bus.overflow     = r_ovf;
   assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_spi_fifo_param.sv
// Directed bench for spi_fifo_param: 261-deep show-ahead
// instance and a 16x16 registered-read instance.
module tb_spi_fifo_param;
   logic clk;
   logic reset;
   logic flush_a;
   logic flush_b;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q [$];
   logic [7:0] exp_b;

   spi_fifo_param_if #(.DATA_W(8), .CNT_W(9)) bus_a ();
   spi_fifo_param_if #(.DATA_W(16), .CNT_W(5)) bus_b ();

   spi_fifo_param #(
      .DATA_W(8), .DEPTH(261), .CNT_W(9), .SHOW_AHEAD(1'b1)
   ) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .flush (flush_a),
      .bus   (bus_a)
   );

   spi_fifo_param #(
      .DATA_W(16), .DEPTH(16), .CNT_W(5), .SHOW_AHEAD(1'b0)
   ) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .flush (flush_b),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      flush_a       = 1'b0;
      flush_b       = 1'b0;
      bus_a.wr_en   = 1'b0;
      bus_a.rd_en   = 1'b0;
      bus_a.data_in = '0;
      bus_a.ae_level = 9'd4;
      bus_a.af_level = 9'd260;
      bus_b.wr_en   = 1'b0;
      bus_b.rd_en   = 1'b0;
      bus_b.data_in = '0;
      bus_b.ae_level = 5'd1;
      bus_b.af_level = 5'd15;
      step();
      step();
      reset = 1'b0;

      chk("rst_empty", 32'(bus_a.empty), 1);
      chk("rst_count", 32'(bus_a.count), 0);
      chk("rst_full", 32'(bus_a.full), 0);
      chk("rst_ae", 32'(bus_a.almost_empty), 1);
      chk("rst_af", 32'(bus_a.almost_full), 0);
      chk("rst_ovf", 32'(bus_a.overflow), 0);
      chk("rst_unf", 32'(bus_a.underflow), 0);
      chk("rst_b_dv", 32'(bus_b.data_valid), 0);
      chk("rst_b_dout", 32'(bus_b.data_out), 0);

      // fill 261 bytes, values wrap through 0xFF back to 0x04
      for (int i = 0; i < 261; i++) begin
         bus_a.wr_en   = 1'b1;
         bus_a.data_in = 8'(i);
         q.push_back(8'(i));
         step();
         if (i == 259) begin
            chk("fill260_full", 32'(bus_a.full), 0);
            chk("fill260_af", 32'(bus_a.almost_full), 1);
         end
      end
      bus_a.wr_en = 1'b0;
      chk("fill_full", 32'(bus_a.full), 1);
      chk("fill_count", 32'(bus_a.count), 261);
      chk("fill_af", 32'(bus_a.almost_full), 1);
      chk("fill_ovf", 32'(bus_a.overflow), 0);

      // simultaneous read+write while full
      for (int k = 0; k < 10; k++) begin
         chk("rw_head", 32'(bus_a.data_out), 32'(q[0]));
         bus_a.wr_en   = 1'b1;
         bus_a.rd_en   = 1'b1;
         bus_a.data_in = 8'(8'h80 + k);
         void'(q.pop_front());
         q.push_back(8'(8'h80 + k));
         step();
      end
      bus_a.wr_en = 1'b0;
      bus_a.rd_en = 1'b0;
      chk("rw_count", 32'(bus_a.count), 261);
      chk("rw_ovf", 32'(bus_a.overflow), 0);
      chk("rw_unf", 32'(bus_a.underflow), 0);

      bus_a.wr_en   = 1'b1;
      bus_a.data_in = 8'hEE;
      step();
      bus_a.wr_en = 1'b0;
      chk("ovf_set", 32'(bus_a.overflow), 1);
      chk("ovf_count", 32'(bus_a.count), 261);

      // drain across the pointer wrap
      for (int i = 0; i < 261; i++) begin
         chk($sformatf("drain%0d", i), 32'(bus_a.data_out),
             32'(q.pop_front()));
         bus_a.rd_en = 1'b1;
         step();
      end
      bus_a.rd_en = 1'b0;
      chk("drain_empty", 32'(bus_a.empty), 1);
      chk("drain_count", 32'(bus_a.count), 0);
      chk("drain_unf", 32'(bus_a.underflow), 0);

      bus_a.rd_en = 1'b1;
      step();
      bus_a.rd_en = 1'b0;
      chk("unf_set", 32'(bus_a.underflow), 1);
      chk("unf_count", 32'(bus_a.count), 0);

      flush_a = 1'b1;
      step();
      flush_a = 1'b0;
      chk("fl1_unf", 32'(bus_a.underflow), 0);
      chk("fl1_ovf", 32'(bus_a.overflow), 0);

      // write+read on empty: read rejected, write lands
      bus_a.wr_en   = 1'b1;
      bus_a.rd_en   = 1'b1;
      bus_a.data_in = 8'hA5;
      step();
      bus_a.wr_en = 1'b0;
      bus_a.rd_en = 1'b0;
      chk("we_unf", 32'(bus_a.underflow), 1);
      chk("we_count", 32'(bus_a.count), 1);
      chk("we_empty", 32'(bus_a.empty), 0);
      chk("we_dout", 32'(bus_a.data_out), 32'hA5);

      for (int i = 0; i < 4; i++) begin
         bus_a.wr_en   = 1'b1;
         bus_a.data_in = 8'(8'h10 + i);
         step();
      end
      bus_a.wr_en = 1'b0;
      chk("ae_count5", 32'(bus_a.count), 5);
      chk("ae_lvl4", 32'(bus_a.almost_empty), 0);
      bus_a.ae_level = 9'd5;
      step();
      chk("ae_lvl5", 32'(bus_a.almost_empty), 1);

      // flush with traffic in the same cycle
      flush_a       = 1'b1;
      bus_a.wr_en   = 1'b1;
      bus_a.rd_en   = 1'b1;
      bus_a.data_in = 8'h77;
      step();
      flush_a     = 1'b0;
      bus_a.wr_en = 1'b0;
      bus_a.rd_en = 1'b0;
      chk("fl2_count", 32'(bus_a.count), 0);
      chk("fl2_empty", 32'(bus_a.empty), 1);
      chk("fl2_ovf", 32'(bus_a.overflow), 0);
      chk("fl2_unf", 32'(bus_a.underflow), 0);
      chk("fl2_af", 32'(bus_a.almost_full), 0);
      step();
      chk("fl2_idle_count", 32'(bus_a.count), 0);
      chk("fl2_idle_unf", 32'(bus_a.underflow), 0);

      // registered-read instance
      exp_b = 8'h00;
      bus_b.wr_en   = 1'b1;
      bus_b.data_in = 16'h1234;
      step();
      bus_b.wr_en = 1'b0;
      chk("b_count1", 32'(bus_b.count), 1);
      chk("b_dv_pre", 32'(bus_b.data_valid), 0);
      bus_b.rd_en = 1'b1;
      step();
      bus_b.rd_en = 1'b0;
      chk("b_dv", 32'(bus_b.data_valid), 1);
      chk("b_dout", 32'(bus_b.data_out), 32'h1234);
      chk("b_empty", 32'(bus_b.empty), 1);
      step();
      chk("b_dv_post", 32'(bus_b.data_valid), 0);
      chk("b_dout_hold", 32'(bus_b.data_out), 32'h1234);
      chk("b_unf", 32'(bus_b.underflow), 32'(exp_b));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=1 exp=0");
      $fatal(1);
   end
endmodule
